// File: rtl/multiplier_pipe.sv
// multiplier_pipe: pipelined signed fixed-point multiplier with optional negation,
// floor or round-half-up rescaling, and an overflow flag.
// Stage 1 registers the full 2W-bit product. Any further stages are plain delay
// registers. The last stage negates, rounds, detects overflow and registers the result.
// Build option MULT_SAT_EN: when it is defined, out-of-range results saturate;
// otherwise they wrap. The ovf flag is generated in both builds.
module multiplier_pipe #(
    parameter int unsigned INT_SIZE  = 16,
    parameter int unsigned FRAC_SIZE = 16,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned ROUND     = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INT_SIZE+FRAC_SIZE-1:0]   in1,
    input  logic [INT_SIZE+FRAC_SIZE-1:0]   in2,
    input  logic                            cond,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [INT_SIZE+FRAC_SIZE-1:0]   out,
    output logic                            ovf
);

    localparam int unsigned W    = INT_SIZE + FRAC_SIZE;
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned NMID = STAGES - 1;
    // Half an output LSB, expressed at the 2W+1-bit rounding width (zero when floor)
    localparam logic [PW:0] RND  = (ROUND != 0) ? (((PW+1)'(1) << FRAC_SIZE) >> 1) : '0;

    logic          en;
    logic [PW-1:0] prod;
    logic [PW-1:0] fin_p;
    logic          fin_c;
    logic          fin_v;

    // The whole pipeline advances together whenever the output slot is free or draining
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // Full-width signed product; 2W bits always hold it exactly
    assign prod = PW'($signed(in1)) * PW'($signed(in2));

    generate
        if (STAGES == 1) begin : g_direct
            assign fin_p = prod;
            assign fin_c = cond;
            assign fin_v = in_valid;
        end else begin : g_pipe
            logic [PW-1:0] p_q [NMID];
            logic          c_q [NMID];
            logic          v_q [NMID];

            // Product register followed by pure delay stages, each with its own valid bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < NMID; i++) begin
                        p_q[i] <= '0;
                        c_q[i] <= 1'b0;
                        v_q[i] <= 1'b0;
                    end
                end else if (en) begin
                    p_q[0] <= prod;
                    c_q[0] <= cond;
                    v_q[0] <= in_valid;
                    for (int unsigned i = 1; i < NMID; i++) begin
                        p_q[i] <= p_q[i-1];
                        c_q[i] <= c_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign fin_p = p_q[NMID-1];
            assign fin_c = c_q[NMID-1];
            assign fin_v = v_q[NMID-1];
        end
    endgenerate

    logic [PW-1:0]      neg_p;
    logic signed [PW:0] sum;
    logic signed [PW:0] res;
    logic               res_ovf;
    logic [W-1:0]       res_out;

    // Negate, round, rescale and range-check the product headed for the output register
    always_comb begin
        neg_p   = fin_c ? PW'(-fin_p) : fin_p;
        sum     = $signed({neg_p[PW-1], neg_p}) + $signed(RND);
        res     = sum >>> FRAC_SIZE;
        res_ovf = !((&res[PW:W-1]) || !(|res[PW:W-1]));
        res_out = res[W-1:0];
`ifdef MULT_SAT_EN
        if (res_ovf) begin
            res_out = res[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Output stage: holds under backpressure, loads a new result only on a valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= fin_v;
            if (fin_v) begin
                out <= res_out;
                ovf <= res_ovf;
            end
        end
    end

endmodule

// File: doc/multiplier_pipe.md
MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

Interface
REQ-001 Parameter INT_SIZE, default 16: integer bits of the signed fixed-point format.
REQ-002 Parameter FRAC_SIZE, default 16: fraction bits; W = INT_SIZE+FRAC_SIZE.
REQ-003 Parameter STAGES, default 2, legal range 1..4: pipeline depth in cycles.
REQ-004 Parameter ROUND, default 0: 0 = floor (truncate), 1 = round half up.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  operand beat valid.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in1, in2  in  W  signed fixed-point operands.
REQ-010 cond  in  1  1 = negate the product.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out  out  W  signed fixed-point result.
REQ-014 ovf  out  1  overflow flag, aligned with out.

Function
REQ-015 Full product p = in1*in2, signed, 2W bits; if cond=1, p = -p, computed at 2W bits (never overflows, including in1=in2=min).
REQ-016 ROUND=0: r = p arithmetically shifted right by FRAC_SIZE (floor toward -inf).
REQ-017 ROUND=1: r = (p + 2^(FRAC_SIZE-1)) arithmetically shifted right by FRAC_SIZE; the addition is done at 2W+1 bits.
REQ-018 ovf = 1 when r is outside the W-bit signed range [-2^(W-1), 2^(W-1)-1].
REQ-019 out is r limited to W bits per REQ-032.
REQ-020 Pipeline advance enable en = !out_valid | out_ready; in_ready = en (combinational).
REQ-021 A beat is accepted when in_valid & in_ready; it appears on out/out_valid exactly STAGES cycles later, provided en stayed 1.
REQ-022 When en=0, every stage holds its data and valid bit; no beat is lost or duplicated.
REQ-023 Each stage carries its own valid bit; bubbles propagate as valid=0 and are not compressed.
REQ-024 Back-to-back beats: one result per cycle while out_ready=1.
REQ-025 The multiply is done in stage 1; negation, rounding and overflow detection are done in the last stage. STAGES>2 adds pure delay registers between them.
REQ-026 Results stay in acceptance order.

Reset
REQ-027 While rst_n=0: all stage valid bits = 0, out_valid=0, out=0, ovf=0, regardless of clock.
REQ-028 in_ready = 1 during and after reset, because out_valid=0.
REQ-029 Reset asserted mid-operation discards all in-flight beats; the first accepted beat after release has full STAGES latency.
REQ-030 Data registers are reset to 0 as well, so no X reaches out.

Configuration
REQ-031 Macro MULT_SAT_EN selects the out-of-range handling.
REQ-032 Defined: on overflow out = 2^(W-1)-1 if r>0, else -2^(W-1). Undefined: out = r[W-1:0] (wrap). ovf is generated in both builds.

Verification (INT_SIZE=16, FRAC_SIZE=16, STAGES=2, ROUND=0 unless stated)
REQ-033 Basic product: in1=0x00020000, in2=0x00018000, cond=0 -> out=0x00030000 and ovf=0, two cycles after acceptance.
REQ-034 Negation and full throughput: same operands with cond=1 -> out=0xFFFD0000; stream 8 beats back-to-back with out_ready=1 -> 8 consecutive results in order.
REQ-035 Overflow: in1=0x7FFF0000, in2=0x00020000 -> ovf=1; out=0x7FFFFFFF with MULT_SAT_EN, out=0xFFFE0000 without.
REQ-036 Rounding: in1=0x00000001, in2=0x00008000 -> out=0x00000000 with ROUND=0, out=0x00000001 with ROUND=1.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> out stable and in_ready=0; after release, all beats delivered once and in order.
REQ-038 Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release, no stale result is output.
